// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and lane helpers for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    // Unsigned widths exist only for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    // f3[1:0]==01 covers both H and HU.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3 == F3_W) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] f3_strobe(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return STRB_B << off;
            2'b01:   return STRB_H << off;
            default: return STRB_W;
        endcase
    endfunction

    function automatic logic [31:0] f3_lane_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts and sign/zero-extends a load result from a memory word
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = word_i >> {off_i, 3'b000};
        result_o = word_i;
        case (funct3_i)
            F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result_o = {24'd0, shifted[7:0]};
            F3_HU:   result_o = {16'd0, shifted[15:0]};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - single-command load/store initiator with variable-latency memory port
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [3:0]        mem_wstrb_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-3:0] addr_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [3:0]        strb_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic        cmd_ok;
    logic        timeout_hit;
    logic [31:0] load_result;

    assign cmd_ok      = f3_legal(funct3_i, we_i) && !f3_misaligned(funct3_i, addr_i[1:0]);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    lsu_load_align u_align (
        .word_i   (mem_rdata_i),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .result_o (load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Bad commands skip ACCESS so mem_req_o never rises for them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = cmd_ok ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (mem_ready_i || timeout_hit) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_RESP);
        err_o       = (state_q == ST_RESP) && err_q;
        mem_req_o   = (state_q == ST_ACCESS);
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wstrb_o = strb_q;
        mem_wdata_o = wdata_q;
        rdata_o     = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            strb_q  <= 4'b0000;
            wdata_q <= 32'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        err_q <= !cmd_ok;
                        cnt_q <= '0;
                        if (cmd_ok) begin
                            addr_q  <= addr_i[ADDR_W-1:2];
                            we_q    <= we_i;
                            f3_q    <= funct3_i;
                            off_q   <= addr_i[1:0];
                            strb_q  <= we_i ? f3_strobe(funct3_i, addr_i[1:0]) : 4'b0000;
                            wdata_q <= f3_lane_data(funct3_i, wdata_i);
                        end
                    end
                end
                ST_ACCESS: begin
                    // A ready in the final cycle beats the timeout.
                    if (mem_ready_i) begin
                        err_q <= 1'b0;
                        if (!we_q) rdata_q <= load_result;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed scoreboard bench for lsu_mem_master
module tb_lsu_mem_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [29:0] mem_addr_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .we_i        (we_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one command from a negedge, plays the memory with the given latency,
    // and compares the completion against the scoreboard entry.
    task automatic do_access(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd, input int lat,
                             input logic [31:0] mword, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wd, input int exp_req,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input logic poke);
        int cycles;
        int req_cycles;
        logic [32:0] exp;
        sb_q.push_back({exp_rdata, exp_err});
        start_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
        @(negedge clk);
        start_i = 1'b0;
        cycles = 0;
        req_cycles = 0;
        while (done_o !== 1'b1 && cycles < 200) begin
            if (mem_req_o === 1'b1) begin
                if (req_cycles == 0) begin
                    check({name, " addr"}, {2'b00, mem_addr_o}, addr >> 2);
                    check({name, " we"}, {31'd0, mem_we_o}, {31'd0, we});
                    check({name, " wstrb"}, {28'd0, mem_wstrb_o}, {28'd0, exp_strb});
                    check({name, " wdata"}, mem_wdata_o, exp_wd);
                end
                req_cycles++;
                if (req_cycles > lat) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = mword;
                end
                if (poke && req_cycles == 1) begin
                    start_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h80;
                end
            end
            @(negedge clk);
            mem_ready_i = 1'b0;
            start_i = 1'b0;
            cycles++;
        end
        check({name, " done"}, {31'd0, done_o}, 32'd1);
        check({name, " req cycles"}, req_cycles, exp_req);
        check({name, " req low at done"}, {31'd0, mem_req_o}, 32'd0);
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            check({name, " rdata"}, rdata_o, exp[32:1]);
            check({name, " err"}, {31'd0, err_o}, {31'd0, exp[0]});
        end
        if (poke) begin
            start_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h84;
        end
        @(negedge clk);
        start_i = 1'b0;
        check({name, " done one cycle"}, {31'd0, done_o}, 32'd0);
        check({name, " idle after"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic done_seen;
        rst = 1'b1; start_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'd0; wdata_i = 32'd0; mem_ready_i = 1'b0; mem_rdata_i = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset done", {31'd0, done_o}, 32'd0);
        check("reset err", {31'd0, err_o}, 32'd0);
        check("reset rdata", rdata_o, 32'd0);
        check("reset req", {31'd0, mem_req_o}, 32'd0);
        check("reset wstrb", {28'd0, mem_wstrb_o}, 32'd0);
        check("reset maddr", {2'b00, mem_addr_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_access("LW",   1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 4'b0000, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0);
        do_access("LB",   1'b0, 3'b000, 32'h13, 32'h0, 0, 32'h80FF1234, 4'b0000, 32'h0, 1, 32'hFFFFFF80, 1'b0, 1'b0);
        do_access("LBU",  1'b0, 3'b100, 32'h13, 32'h0, 1, 32'h80FF1234, 4'b0000, 32'h0, 2, 32'h00000080, 1'b0, 1'b0);
        do_access("LH",   1'b0, 3'b001, 32'h12, 32'h0, 0, 32'h80FF1234, 4'b0000, 32'h0, 1, 32'hFFFF80FF, 1'b0, 1'b0);
        do_access("LHU",  1'b0, 3'b101, 32'h12, 32'h0, 0, 32'h80FF1234, 4'b0000, 32'h0, 1, 32'h000080FF, 1'b0, 1'b0);
        do_access("SH",   1'b1, 3'b001, 32'h12, 32'h1234ABCD, 1, 32'h55555555, 4'b1100, 32'hABCDABCD, 2, 32'h000080FF, 1'b0, 1'b0);
        do_access("SB",   1'b1, 3'b000, 32'h01, 32'h0000005A, 0, 32'h55555555, 4'b0010, 32'h5A5A5A5A, 1, 32'h000080FF, 1'b0, 1'b0);
        do_access("LWmis", 1'b0, 3'b010, 32'h11, 32'h0, 0, 32'h11111111, 4'b0000, 32'h0, 0, 32'h000080FF, 1'b1, 1'b0);
        do_access("LHmis", 1'b0, 3'b001, 32'h03, 32'h0, 0, 32'h11111111, 4'b0000, 32'h0, 0, 32'h000080FF, 1'b1, 1'b0);
        do_access("Lf011", 1'b0, 3'b011, 32'h20, 32'h0, 0, 32'h11111111, 4'b0000, 32'h0, 0, 32'h000080FF, 1'b1, 1'b0);
        do_access("SBU",   1'b1, 3'b100, 32'h20, 32'h0, 0, 32'h11111111, 4'b0000, 32'h0, 0, 32'h000080FF, 1'b1, 1'b0);
        do_access("LWto",  1'b0, 3'b010, 32'h40, 32'h0, 1000, 32'h22222222, 4'b0000, 32'h0, TO, 32'h000080FF, 1'b1, 1'b0);
        do_access("LWpost", 1'b0, 3'b010, 32'h44, 32'h0, 0, 32'h13579BDF, 4'b0000, 32'h0, 1, 32'h13579BDF, 1'b0, 1'b1);
        check("idle stays idle", {31'd0, mem_req_o}, 32'd0);
        check("scoreboard empty", sb_q.size(), 32'd0);

        start_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h50; wdata_i = 32'hCAFEF00D;
        @(negedge clk);
        start_i = 1'b0;
        check("rst-mid req", {31'd0, mem_req_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst-mid req low", {31'd0, mem_req_o}, 32'd0);
        check("rst-mid busy", {31'd0, busy_o}, 32'd0);
        check("rst-mid rdata", rdata_o, 32'd0);
        check("rst-mid wstrb", {28'd0, mem_wstrb_o}, 32'd0);
        check("rst-mid wdata", mem_wdata_o, 32'd0);
        check("rst-mid we", {31'd0, mem_we_o}, 32'd0);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            done_seen = done_seen | done_o;
        end
        check("rst-mid no done", {31'd0, done_seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
